avr_uart_tx: RTL and testbench
==============================

AVR_UART_TX -- requirements
Module: avr_uart_tx

Interface
REQ-001 Parameter CLK_PER_BIT, default 100, clk cycles per serial bit (50 MHz / 500 kbaud); legal range >= 2.
REQ-002 Parameter FIFO_DEPTH, default 4, byte buffer entries; power of two, >= 2.
REQ-003 clk  input  1  system clock; the block's only clock; all flops on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 data_in  input  8  byte to transmit.
REQ-006 data_valid  input  1  data_in valid this cycle.
REQ-007 data_ready  output  1  block can accept a byte this cycle.
REQ-008 avr_rx_busy  input  1  AVR receive buffer full; asynchronous to clk.
REQ-009 tx  output  1  serial line to AVR Rx, idle high.
REQ-010 busy  output  1  frame in progress or FIFO non-empty.

Function
REQ-011 Byte SHALL be accepted on a rising edge where data_valid && data_ready; byte is written to FIFO tail.
REQ-012 data_ready SHALL equal !fifo_full (combinational from registered full flag); no write when full, no overwrite.
REQ-013 Frame format SHALL be 8N1: start bit 0, eight data bits LSB first, one stop bit 1; each bit held exactly CLK_PER_BIT cycles.
REQ-014 avr_rx_busy SHALL pass through a 2-flop synchronizer before use; busy_s denotes the synchronized value.
REQ-015 FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE: tx=1; if FIFO non-empty && !busy_s, pop head into shift register, clear bit counter, go to START.
REQ-017 START: tx=0 for CLK_PER_BIT cycles, then go to DATA.
REQ-018 DATA: tx=shift[0]; after CLK_PER_BIT cycles shift right and increment bit index; after bit index 7 completes go to STOP.
REQ-019 STOP: tx=1 for CLK_PER_BIT cycles, then go to IDLE; a queued byte MAY start on the next edge (no extra idle bit required).
REQ-020 Latency: byte accepted at edge k into empty FIFO with FSM in IDLE and busy_s=0 SHALL drive tx low after edge k+1.
REQ-021 busy_s rising mid-frame SHALL NOT abort or stretch the frame; it only blocks the next START.
REQ-022 Simultaneous write and pop SHALL both take effect; occupancy unchanged; full flag uses occupancy count, not pointer equality.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
REQ-024 Baud counter width $clog2(CLK_PER_BIT); counts 0..CLK_PER_BIT-1 then wraps.
REQ-025 busy SHALL be 1 whenever state != IDLE or FIFO count != 0.
REQ-026 tx SHALL be registered (glitch-free output).

Reset
REQ-027 While rst_n=0: tx=1, data_ready=0, busy=0, state=IDLE, FIFO empty, counters 0, synchronizer flops 1 (treat AVR as busy).
REQ-028 Reset mid-frame SHALL abandon the frame immediately and discard all queued bytes; tx returns high asynchronously.
REQ-029 After rst_n rises, data_ready=1 from the first edge; no frame starts until busy_s has been sampled low.

Structure
REQ-030 Shared package avr_uart_pkg SHALL hold the FSM state enum and default CLK_PER_BIT / FIFO_DEPTH constants.
REQ-031 FIFO SHALL be one sub-module byte_fifo (synchronous, count-based full/empty, same clk/rst_n).
REQ-032 FSM, baud counter, shift register, and synchronizer remain in avr_uart_tx.

Verification (CLK_PER_BIT=4, FIFO_DEPTH=4)
REQ-033 Send 0xA5, avr_rx_busy=0 -> tx low after edge k+1, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; busy falls after stop bit.
REQ-034 Push 0x01..0x05 back-to-back, busy high -> data_ready low after 4 accepted; 5th held until slot frees; all 5 transmitted in order.
REQ-035 Hold avr_rx_busy=1, push 0x3C -> tx stays 1; release -> start bit within 3 cycles of release edge; byte 0x3C correct.
REQ-036 Raise avr_rx_busy during DATA bit 3 of 0xFF -> frame completes unchanged; next queued byte waits for release.
REQ-037 Assert rst_n=0 during DATA with 2 bytes queued -> tx=1 immediately, data_ready=0, busy=0; after release nothing transmitted.
REQ-038 FIFO full, data_valid=1 at the edge FSM pops -> data_ready=0, no write that cycle; write accepted next cycle; count stays 4.

Source files
------------

// File: rtl/avr_uart_pkg.sv
// Shared types and default parameters for the AVR-facing UART transmitter.
// The FSM state enum lives here so the top level and any future siblings agree on it.
package avr_uart_pkg;

    localparam int DEF_CLK_PER_BIT = 100;  // 50 MHz clk, 500 kbaud line
    localparam int DEF_FIFO_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/avr_uart_byte_fifo.sv
// Byte FIFO with count-based full/empty and a registered head word that is
// always valid one cycle after a write, so the reader can pop without waiting.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             full_reg;
    logic [7:0]       head_reg;
    logic             wr_fire;
    logic             rd_fire;

    assign wr_fire = wr_en && !full_reg;
    assign rd_fire = rd_en && (count_reg != '0);

    always_comb begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(rd_fire);
        count_next  = count_reg + CNT_W'(wr_fire) - CNT_W'(rd_fire);
    end

    // full_reg comes out of reset set so the writer is held off until the
    // first clock edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b1;
        end else begin
            if (wr_fire) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            full_reg   <= (count_next == CNT_W'(DEPTH));
        end
    end

    // Storage has no reset. The head register reads the slot the read pointer
    // will point at next, bypassing the write data when that slot is being filled now.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_reg] <= wr_data;
        end
        if (wr_fire && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= wr_data;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

    assign rd_data = head_reg;
    assign full    = full_reg;
    assign empty   = (count_reg == '0);

endmodule

// File: rtl/avr_uart_tx.sv
// 8N1 UART transmitter feeding an AVR receiver, with a small byte FIFO and
// flow control from the AVR's receive-buffer-full line.
module avr_uart_tx
    import avr_uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic       avr_rx_busy,
    output logic       tx,
    output logic       busy
);

    localparam int              BAUD_W    = $clog2(CLK_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);

    tx_state_e         state_reg;
    logic [BAUD_W-1:0] baud_reg;
    logic [2:0]        bit_idx_reg;
    logic [7:0]        shift_reg;
    logic              tx_reg;
    logic [1:0]        sync_reg;
    logic              busy_s;

    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_head;
    logic              baud_done;
    logic              pop;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (data_valid),
        .wr_data (data_in),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Synchronizer resets to "AVR busy" so nothing is sent until the real
    // line level has been seen low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], avr_rx_busy};
        end
    end

    assign busy_s    = sync_reg[1];
    assign baud_done = (baud_reg == BAUD_LAST);

    // A new frame may start from IDLE, or straight out of the last stop-bit
    // cycle so back-to-back bytes carry no extra idle bit.
    assign pop = !fifo_empty && !busy_s &&
                 ((state_reg == IDLE) || ((state_reg == STOP) && baud_done));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg   <= 1'b1;
                    baud_reg <= '0;
                    if (pop) begin
                        shift_reg   <= fifo_head;
                        bit_idx_reg <= '0;
                        tx_reg      <= 1'b0;
                        state_reg   <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_reg  <= '0;
                        tx_reg    <= shift_reg[0];
                        state_reg <= DATA;
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            shift_reg   <= shift_reg >> 1;
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_reg <= '0;
                        if (pop) begin
                            shift_reg   <= fifo_head;
                            bit_idx_reg <= '0;
                            tx_reg      <= 1'b0;
                            state_reg   <= START;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tx         = tx_reg;
    assign data_ready = !fifo_full;
    assign busy       = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_avr_uart_tx.sv
// Directed and random bench for avr_uart_tx: a line-level 8N1 receiver model
// decodes tx and is compared against the queue of bytes handed to the block.
module tb_avr_uart_tx;

    localparam int N = 4;
    localparam int D = 4;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b1;
    logic [7:0] data_in     = 8'h00;
    logic       data_valid  = 1'b0;
    logic       avr_rx_busy = 1'b0;
    logic       data_ready;
    logic       tx;
    logic       busy;

    int vec  = 0;
    int errs = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    avr_uart_tx #(
        .CLK_PER_BIT (N),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .avr_rx_busy (avr_rx_busy),
        .tx          (tx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Line receiver: a frame is 10 bits of N samples each; every sample in a bit
    // must match the first one, start must be 0 and stop must be 1.
    bit         mon_active = 1'b0;
    bit         mon_stable = 1'b1;
    int         mon_i      = 0;
    int         frame_err  = 0;
    logic [9:0] mon_bits   = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && tx === 1'b0) begin
                mon_active = 1'b1;
                mon_i      = 0;
                mon_stable = 1'b1;
            end
            if (mon_active) begin
                if (mon_i % N == 0) mon_bits[mon_i / N] = tx;
                else if (tx !== mon_bits[mon_i / N]) mon_stable = 1'b0;
                if (mon_i == 10 * N - 1) begin
                    mon_active = 1'b0;
                    if (mon_stable && mon_bits[0] === 1'b0 && mon_bits[9] === 1'b1)
                        rx_q.push_back(mon_bits[8:1]);
                    else
                        frame_err++;
                end else begin
                    mon_i++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        data_in    = b;
        data_valid = 1'b1;
        @(negedge clk);
        while (data_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready_timeout", 32'(data_ready), 32'd1);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        exp_q.push_back(b);
        $display("push byte %02h after %0d stall cycles", b, n);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || mon_active) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", 32'(n < 3000), 32'd1);
    endtask

    task automatic drain();
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rx_present", 32'(rx_q.size() > 0), 32'd1);
            if (rx_q.size() > 0) begin
                $display("rx byte %02h expected %02h", rx_q[0], e);
                chk("rx_byte", 32'(rx_q.pop_front()), 32'(e));
            end
        end
        chk("rx_extra", 32'(rx_q.size()), 32'd0);
        chk("frame_err", 32'(frame_err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        bit         all_hi;
        logic [7:0] r;

        // Reset values, then ready on the first edge after release
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(data_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(data_ready), 32'd1);
        chk("post_rst_tx", 32'(tx), 32'd1);
        repeat (4) @(negedge clk);

        // 0xA5: latency to start bit and busy duration
        data_in    = 8'hA5;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        exp_q.push_back(8'hA5);
        chk("lat_edge_k_tx", 32'(tx), 32'd1);
        chk("lat_edge_k_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("lat_edge_k1_tx", 32'(tx), 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("busy_fall_cycles", 32'(n), 32'(10 * N));
        wait_idle();
        drain();

        // Five bytes back-to-back with the AVR holding off: FIFO fills at 4
        avr_rx_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        fork
            begin
                for (int i = 1; i <= 4; i++) push(8'(i));
                @(negedge clk);
                chk("full_after_4", 32'(data_ready), 32'd0);
                push(8'h05);
            end
            begin
                repeat (30) @(negedge clk);
                avr_rx_busy = 1'b0;
            end
        join
        wait_idle();
        drain();

        // Held off by the AVR, then release and start within 3 edges
        avr_rx_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push(8'h3C);
        all_hi = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1) all_hi = 1'b0;
        end
        chk("held_tx_high", 32'(all_hi), 32'd1);
        chk("held_busy", 32'(busy), 32'd1);
        @(negedge clk) avr_rx_busy = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (tx !== 1'b0 && n < 10);
        chk("release_latency_le3", 32'(n <= 3), 32'd1);
        wait_idle();
        drain();

        // AVR goes busy during data bit 3 of 0xFF: frame finishes, next waits
        r = 8'($urandom);
        push(8'hFF);
        push(r);
        repeat (17) @(posedge clk);
        #1;
        avr_rx_busy = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("midframe_first_done", 32'(rx_q.size()), 32'd1);
        all_hi = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1) all_hi = 1'b0;
        end
        chk("midframe_next_held", 32'(all_hi), 32'd1);
        chk("midframe_busy", 32'(busy), 32'd1);
        @(negedge clk) avr_rx_busy = 1'b0;
        wait_idle();
        drain();

        // Full FIFO with a write pending when the FSM pops
        avr_rx_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) push(8'($urandom));
        chk("fill_ready_low", 32'(data_ready), 32'd0);
        fork
            push(8'($urandom));
            begin
                repeat (10) @(negedge clk);
                avr_rx_busy = 1'b0;
            end
        join
        chk("refill_full", 32'(data_ready), 32'd0);
        wait_idle();
        drain();

        // Random bytes with random gaps
        for (int i = 0; i < 12; i++) begin
            push(8'($urandom));
            repeat ($urandom_range(0, 50)) @(posedge clk);
            #1;
        end
        wait_idle();
        drain();

        // Reset mid-frame with two bytes queued
        for (int i = 0; i < 3; i++) push(8'($urandom));
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_ready", 32'(data_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("midrst_no_rx", 32'(rx_q.size()), 32'd0);
        chk("midrst_idle_busy", 32'(busy), 32'd0);
        chk("midrst_idle_tx", 32'(tx), 32'd1);
        chk("midrst_frame_err", 32'(frame_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
